decrement: RTL and testbench

Registered 20-bit decrementer for the datapath: subtracts one from a 20-bit operand and presents the result, a zero flag and a borrow/underflow flag one clock later. It serves as the address/counter step unit between the operand bus and downstream consumers. Input is qualified by a valid strobe; output holds its last value when no new operand arrives.

---
 rtl/decrement.sv | 92 +++++++++
 tb/tb_decrement.sv | 130 +++++++++++++
 2 files changed

// File: rtl/decrement.sv
// ---------------------------------------------------------------------------
// decrement -- registered WIDTH-bit decrementer (default 20 bits)
//
// Subtracts one from an unsigned operand and registers the result together
// with a zero flag and a borrow (underflow) flag. Results appear one clock
// after the operand is captured; outputs hold when no operand arrives.
//
// Build option:
//   DECREMENT_SAT_EN  defined   -> saturating: in=0 gives out=0, zero=1
//                     undefined -> wrap:       in=0 gives out=all ones
//   borrow reflects in==0 in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand qualifier, operand captured when high
//   in         operand (unsigned, WIDTH bits)
//   out        registered result
//   out_valid  high for the cycle after each accepted operand
//   zero       registered, captured result == 0
//   borrow     registered, captured operand == 0
// ---------------------------------------------------------------------------
module decrement #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             zero,
    output logic             borrow
);

    localparam int GW = 5;                  // bits per lookahead group
    localparam int NG = (WIDTH + GW - 1) / GW;

    logic [NG-1:0]    grp_zero;   // group of operand bits is all zero
    logic [NG:0]      grp_pre;    // every group below this one is all zero
    logic [WIDTH-1:0] flip;       // bit flips: all lower operand bits are zero
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] result;
    logic             in_zero;

    // Group-level all-zero detect and prefix across groups. The borrow only
    // has to ripple across NG group terms plus at most GW-1 bits inside a
    // group, instead of across WIDTH bits.
    assign grp_pre[0] = 1'b1;
    for (genvar g = 0; g < NG; g++) begin : g_grp
        localparam int LO = g * GW;
        localparam int HI = ((g + 1) * GW > WIDTH) ? WIDTH - 1 : (g + 1) * GW - 1;
        assign grp_zero[g]  = ~|in[HI:LO];
        assign grp_pre[g+1] = grp_pre[g] & grp_zero[g];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int G = i / GW;
        localparam int J = i % GW;
        if (J == 0) begin : g_first
            assign flip[i] = grp_pre[G];
        end else begin : g_rest
            assign flip[i] = grp_pre[G] & ~|in[i-1:G*GW];
        end
    end

    assign diff    = in ^ flip;
    assign in_zero = grp_pre[NG];

`ifdef DECREMENT_SAT_EN
    assign result = in_zero ? '0 : diff;
`else
    assign result = diff;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            zero      <= 1'b0;
            borrow    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out    <= result;
                zero   <= ~|result;
                borrow <= in_zero;
            end
        end
    end

endmodule

// File: tb/tb_decrement.sv
// ---------------------------------------------------------------------------
// tb_decrement -- self-checking bench for decrement (WIDTH=20).
// Expected values come from a plain arithmetic model of the decrement rules.
// ---------------------------------------------------------------------------
module tb_decrement;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in;
    logic [W-1:0] out;
    logic         out_valid;
    logic         zero;
    logic         borrow;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [W-1:0] m_out;
    logic         m_zero, m_borrow, m_valid;

    decrement #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .zero      (zero),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"},       out,                m_out);
        check({tag, ".zero"},      {19'd0, zero},      {19'd0, m_zero});
        check({tag, ".borrow"},    {19'd0, borrow},    {19'd0, m_borrow});
        check({tag, ".out_valid"}, {19'd0, out_valid}, {19'd0, m_valid});
    endtask

    // Model: result of an accepted operand, from the arithmetic rule.
    task automatic model_accept(input logic [W-1:0] d);
        int unsigned r;
`ifdef DECREMENT_SAT_EN
        r = (d == 0) ? 0 : int'(d) - 1;
`else
        r = (int'(d) + (1 << W) - 1) % (1 << W);
`endif
        m_out    = W'(r);
        m_zero   = (r == 0);
        m_borrow = (d == 0);
        m_valid  = 1'b1;
    endtask

    // Drive at negedge, let one rising edge pass, check 1 time unit later.
    task automatic step(input string tag, input logic v, input logic [W-1:0] d);
        @(negedge clk);
        in_valid = v;
        in       = d;
        @(posedge clk);
        if (v) model_accept(d);
        else   m_valid = 1'b0;
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] r;
        rst = 1'b1; in_valid = 1'b1; in = 20'h00005;
        m_out = '0; m_zero = 1'b0; m_borrow = 1'b0; m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_all("reset");

        @(negedge clk);
        rst = 1'b0;
        step("pre", 1'b1, 20'h00005);

        // asynchronous reset mid-cycle with an operand pending
        #2;
        in_valid = 1'b1; in = 20'h00005;
        rst = 1'b1;
        m_out = '0; m_zero = 1'b0; m_borrow = 1'b0; m_valid = 1'b0;
        #1 check_all("async_rst");
        @(posedge clk);
        #1 check_all("rst_held");
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        step("basic",      1'b1, 20'h00010);
        step("basic_hold", 1'b0, 20'h12345);

        step("grp0", 1'b1, 20'h00020);
        step("grp1", 1'b1, 20'h08000);
        step("grp2", 1'b1, 20'h80000);

        step("one",   1'b1, 20'h00001);
        step("max",   1'b1, 20'hFFFFF);
        step("under", 1'b1, 20'h00000);
        step("under_hold", 1'b0, 20'h00001);

        for (int i = 0; i < 10; i++) begin
            r = W'($urandom);
            step($sformatf("rand%0d", i), 1'b1, r);
        end
        step("rand_end", 1'b0, 20'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against an unexpected stall.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
